// File: rtl/ram_dma.sv
// Sequential DMA initiator for the data RAM: streams a block out of the RAM (READ) or into it (WRITE).
// Optional RAM_DMA_STALL_CNT_EN adds stall_cnt_o, a saturating count of stream-stalled cycles.
module ram_dma #(
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [31:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ram_req_o,
    output logic [31:0]      ram_addr_o,
    output logic             ram_we_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      rd_ram_i,
`ifdef RAM_DMA_STALL_CNT_EN
    output logic [15:0]      stall_cnt_o,
`endif
    output logic             m_valid_o,
    output logic [31:0]      m_data_o,
    input  logic             m_ready_i,
    input  logic             s_valid_i,
    input  logic [31:0]      s_data_i,
    output logic             s_ready_o
);

    // state    | meaning
    // ST_IDLE  | waiting for start_i
    // ST_READ  | RAM -> m stream, one load per free output slot
    // ST_WRITE | s stream -> RAM, one write per s_valid_i
    // ST_FLUSH | all words read, waiting for the last one to be taken
    // ST_DONE  | one-cycle done_o pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t           state;
    logic [31:0]      addr;
    logic [LEN_W-1:0] rem;
    logic             load;
    logic             wr_beat;

    assign load    = (state == ST_READ) && (!m_valid_o || m_ready_i) && (rem != '0);
    assign wr_beat = (state == ST_WRITE) && s_valid_i;

    assign ram_req_o   = load || wr_beat;
    assign ram_we_o    = wr_beat;
    assign ram_addr_o  = addr;
    assign ram_wdata_o = wr_beat ? s_data_i : 32'd0;
    assign s_ready_o   = (state == ST_WRITE);
    assign busy_o      = (state == ST_READ) || (state == ST_WRITE) || (state == ST_FLUSH);
    assign done_o      = (state == ST_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            addr      <= 32'd0;
            rem       <= '0;
            m_valid_o <= 1'b0;
            m_data_o  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr <= {base_addr_i[31:2], 2'b00};
                        rem  <= len_i;
                        if (len_i == '0)
                            state <= ST_DONE;
                        else
                            state <= dir_i ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    // a handshake here always coincides with a load, so the slot is refilled
                    if (load) begin
                        m_data_o  <= rd_ram_i;
                        m_valid_o <= 1'b1;
                        addr      <= addr + 32'd4;
                        rem       <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1))
                            state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (m_valid_o && m_ready_i) begin
                        m_valid_o <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (s_valid_i) begin
                        addr <= addr + 32'd4;
                        rem  <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RAM_DMA_STALL_CNT_EN
    logic stall;
    assign stall = (((state == ST_READ) || (state == ST_FLUSH)) && m_valid_o && !m_ready_i)
                || ((state == ST_WRITE) && !s_valid_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt_o <= 16'd0;
        else if ((state == ST_IDLE) && start_i)
            stall_cnt_o <= 16'd0;
        else if (stall && (stall_cnt_o != 16'hFFFF))
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma with a small combinational-read RAM model.
module tb_ram_dma;
    localparam int LEN_W = 13;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start_i = 1'b0;
    logic             dir_i = 1'b0;
    logic [31:0]      base_addr_i = 32'd0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o, done_o, ram_req_o, ram_we_o;
    logic [31:0]      ram_addr_o, ram_wdata_o, rd_ram_i;
    logic             m_valid_o, m_ready_i = 1'b0;
    logic [31:0]      m_data_o;
    logic             s_valid_i = 1'b0, s_ready_o;
    logic [31:0]      s_data_i = 32'd0;
`ifdef RAM_DMA_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    logic [31:0] mem [0:4095];
    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .dir_i(dir_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_wdata_o(ram_wdata_o), .rd_ram_i(rd_ram_i),
`ifdef RAM_DMA_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o)
    );

    assign rd_ram_i = mem[ram_addr_o[13:2]];

    always @(posedge clk) begin
        if (ram_req_o && ram_we_o)
            mem[ram_addr_o[13:2]] = ram_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_mvalid", {31'd0, m_valid_o}, 32'd0);
        check("rst_mdata", m_data_o, 32'd0);
        check("rst_sready", {31'd0, s_ready_o}, 32'd0);
        check("rst_req", {31'd0, ram_req_o}, 32'd0);
        check("rst_we", {31'd0, ram_we_o}, 32'd0);
        check("rst_addr", ram_addr_o, 32'd0);
        check("rst_wdata", ram_wdata_o, 32'd0);
`ifdef RAM_DMA_STALL_CNT_EN
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    endtask

    // READ base 0x10, len 4, ready held: loads cycles 1..4, data cycles 2..5, done cycle 6
    task automatic run_read_basic();
        @(negedge clk);
        start_i = 1'b1; dir_i = 1'b0; base_addr_i = 32'h10; len_i = 13'd4; m_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            check($sformatf("rd_done_c%0d", k), {31'd0, done_o}, {31'd0, k == 6});
            if (k <= 4) begin
                check($sformatf("rd_req_c%0d", k), {31'd0, ram_req_o}, 32'd1);
                check($sformatf("rd_addr_c%0d", k), ram_addr_o, 32'h10 + 32'(4 * (k - 1)));
            end else begin
                check($sformatf("rd_noreq_c%0d", k), {31'd0, ram_req_o}, 32'd0);
            end
            if (k >= 2 && k <= 5) begin
                check($sformatf("rd_valid_c%0d", k), {31'd0, m_valid_o}, 32'd1);
                check($sformatf("rd_data_c%0d", k), m_data_o, 32'hA0 + 32'(k - 2));
            end else begin
                check($sformatf("rd_novalid_c%0d", k), {31'd0, m_valid_o}, 32'd0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        automatic logic ready_pat [1:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        automatic int nrx = 0;
        automatic int done_cyc = 0;
        automatic int we_cnt = 0;
        automatic int req_cnt = 0;

        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        for (int i = 0; i < 4; i++) mem[4 + i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 3; i++) mem[16 + i] = 32'hB0 + 32'(i);

        #13;
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;

        run_read_basic();

        // READ len 3 with back-pressure; a start pulse mid-transfer must be ignored
        @(negedge clk);
        start_i = 1'b1; dir_i = 1'b0; base_addr_i = 32'h40; len_i = 13'd3;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            m_ready_i = (c <= 7) ? ready_pat[c] : 1'b1;
            start_i = (c == 3);
            dir_i = (c == 3);
            len_i = (c == 3) ? 13'd7 : 13'd3;
            #1;
            if (m_valid_o && m_ready_i) begin
                check($sformatf("bp_rx%0d", nrx), m_data_o, 32'hB0 + 32'(nrx));
                nrx++;
            end else if (m_valid_o) begin
                check($sformatf("bp_hold_c%0d", c), m_data_o, 32'hB0 + 32'(nrx));
                check($sformatf("bp_noreq_c%0d", c), {31'd0, ram_req_o}, 32'd0);
            end
            if (done_o) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        start_i = 1'b0; dir_i = 1'b0;
        check("bp_count", 32'(nrx), 32'd3);
        check("bp_done_cyc", 32'(done_cyc), 32'd8);
`ifdef RAM_DMA_STALL_CNT_EN
        check("bp_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

        // WRITE base 0x3 (word 0), len 3, gap in cycle 2
        @(negedge clk);
        start_i = 1'b1; dir_i = 1'b1; base_addr_i = 32'h3; len_i = 13'd3; m_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            s_valid_i = (c == 1) || (c == 3) || (c == 4);
            s_data_i = (c == 1) ? 32'h11 : (c == 3) ? 32'h22 : (c == 4) ? 32'h33 : 32'hDEAD;
            #1;
            if (c == 1) check("wr_sready", {31'd0, s_ready_o}, 32'd1);
            if (c == 3) check("wr_addr_c3", ram_addr_o, 32'h4);
            if (ram_we_o) we_cnt++;
            if (done_o && done_cyc == 0) done_cyc = c;
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        #1;
        check("wr_we_cnt", 32'(we_cnt), 32'd3);
        check("wr_done_cyc", 32'(done_cyc), 32'd5);
        check("wr_mem0", mem[0], 32'h11);
        check("wr_mem1", mem[1], 32'h22);
        check("wr_mem2", mem[2], 32'h33);
        check("wr_mem3", mem[3], 32'h0);
        check("wr_sready_idle", {31'd0, s_ready_o}, 32'd0);
`ifdef RAM_DMA_STALL_CNT_EN
        check("wr_stall_cnt", {16'd0, stall_cnt}, 32'd1);
`endif

        // zero length in both directions
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            start_i = 1'b1; dir_i = d[0]; base_addr_i = 32'h100; len_i = '0;
            req_cnt = 0;
            @(negedge clk);
            start_i = 1'b0;
            #1;
            check($sformatf("z%0d_done", d), {31'd0, done_o}, 32'd1);
            check($sformatf("z%0d_busy", d), {31'd0, busy_o}, 32'd0);
            if (ram_req_o) req_cnt++;
            @(negedge clk);
            #1;
            check($sformatf("z%0d_done_off", d), {31'd0, done_o}, 32'd0);
            if (ram_req_o) req_cnt++;
            check($sformatf("z%0d_noreq", d), 32'(req_cnt), 32'd0);
        end

        // async reset while a word is held on the stream
        @(negedge clk);
        start_i = 1'b1; dir_i = 1'b0; base_addr_i = 32'h10; len_i = 13'd4; m_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; m_ready_i = 1'b0;
        @(negedge clk);
        #1;
        check("mid_valid_pre", {31'd0, m_valid_o}, 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;

        run_read_basic();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/ram_dma.md
# ram_dma

Sequential DMA initiator for the data RAM. It drives the RAM's request/address/write-enable/write-data port and consumes its combinational read data. On a start pulse it either streams a block of 32-bit words out of the RAM onto a valid/ready master stream (READ), or writes a block from a valid/ready slave stream into the RAM (WRITE). It sits between the data RAM and the compute array's operand/result streams.

## Interface
- LEN_W, 13: width of word-count field; max block 2^LEN_W-1 words (covers the full 4096-word RAM).
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start request; sampled only in IDLE.
- dir_i  in  1  0 = READ (RAM→stream), 1 = WRITE (stream→RAM); sampled with start_i.
- base_addr_i  in  32  byte address of first word; bits [1:0] forced to 0.
- len_i  in  LEN_W  number of words to transfer.
- busy_o  out  1  high in READ, WRITE, FLUSH.
- done_o  out  1  one-cycle pulse at end of transfer.
- ram_req_o  out  1  RAM access request.
- ram_addr_o  out  32  RAM byte address.
- ram_we_o  out  1  RAM write enable.
- ram_wdata_o  out  32  RAM write data.
- rd_ram_i  in  32  RAM read data, valid combinationally in the same cycle as ram_req_o/ram_addr_o.
- m_valid_o / m_data_o[31:0] / m_ready_i: READ output stream.
- s_valid_i / s_data_i[31:0] / s_ready_o: WRITE input stream.

## Operation
- Registers: addr (32 b), rem (LEN_W b), state, m_valid_o, m_data_o.
- IDLE: start_i=1 latches addr=base_addr_i&~3, rem=len_i; len_i=0 → DONE; else dir_i selects READ or WRITE. start_i outside IDLE is ignored.
- READ: load = (!m_valid_o || m_ready_i) && rem!=0. ram_req_o=load, ram_we_o=0, ram_addr_o=addr. On load: m_data_o<=rd_ram_i, m_valid_o<=1, addr+=4, rem-=1. Load with rem==1 → FLUSH.
- FLUSH: no RAM access; when m_valid_o&&m_ready_i, m_valid_o<=0, → DONE.
- Outside READ/FLUSH, a handshake clears m_valid_o only via FLUSH; m_valid_o never drops without handshake.
- WRITE: s_ready_o=1. On s_valid_i: ram_req_o=ram_we_o=1, ram_addr_o=addr, ram_wdata_o=s_data_i; addr+=4, rem-=1. Handshake with rem==1 → DONE.
- DONE: done_o=1, busy_o=0; next cycle → IDLE.
- Outside active beats: ram_req_o=ram_we_o=0, ram_wdata_o=0, ram_addr_o=addr. s_ready_o=0 outside WRITE.
- addr wraps modulo 2^32; no range check (RAM decodes addr>>2).

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, m_valid_o 0, m_data_o 0, s_ready_o 0, ram_req_o 0, ram_we_o 0, ram_addr_o 0, ram_wdata_o 0, addr 0, rem 0.
- READ, m_ready_i held 1, start at cycle 0: RAM reads cycles 1..n, m_valid_o high cycles 2..n+1, done_o cycle n+2. One word/cycle sustained.
- m_ready_i low: m_data_o/m_valid_o hold; no RAM request issued.
- WRITE, s_valid_i held 1, start at cycle 0: RAM writes at edges ending cycles 1..n, done_o cycle n+1.
- len_i=0: done_o cycle 1, no RAM access.
- rstn low at any point: immediate return to reset values; an in-flight stream word is discarded.

## Configuration
- RAM_DMA_STALL_CNT_EN defined: adds output stall_cnt_o[15:0]; cleared on accepted start_i, increments (saturating at 0xFFFF) each cycle in READ/FLUSH with m_valid_o&&!m_ready_i, or in WRITE with !s_valid_i; holds in IDLE/DONE; reset 0.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- READ base 0x10, len 4, RAM words 4..7 = 0xA0..0xA3, m_ready_i=1 -> m_data_o 0xA0,0xA1,0xA2,0xA3 in cycles 2..5, ram_addr_o 0x10,0x14,0x18,0x1C, done_o cycle 6.
- READ len 3, m_ready_i toggling 1,0,0,1,... -> no word lost or duplicated, m_data_o stable while stalled; with RAM_DMA_STALL_CNT_EN, stall_cnt_o equals stalled-valid cycles.
- WRITE base 0x3 (forced 0x0), len 3, s_data_i 0x11,0x22,0x33 with one s_valid_i gap -> RAM words 0..2 = 0x11,0x22,0x33, ram_we_o exactly 3 cycles, done_o after last.
- len 0 in either direction -> done_o next cycle, ram_req_o never asserted.
- start_i pulsed during READ -> ignored, transfer completes with original length.
- rstn asserted mid-READ with m_valid_o=1 -> all outputs return to reset values asynchronously; fresh start then behaves as test 1.
